tcam_lookup: RTL and testbench
==============================

# tcam_lookup

Parametrised, runtime-programmable ternary match table, the successor to the fixed 4-bit `cam`/`tcam` pair. It takes a key with a valid strobe and returns the action of the lowest-index matching valid entry, plus hit flag and index, after a fixed two-cycle pipeline. Entries are written through a side port by the control plane while lookups continue. It sits in the match stage of the switch pipeline, between header parse and action execution.

## Interface
Parameters:
- KEY_W, 4: key width in bits
- DEPTH, 16: number of entries; power of two, at least 2
- ACT_W, 4: action width in bits
- DEF_ACT, 0: action returned on miss

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- data_in_vld  in  1  lookup request strobe
- data_in  in  KEY_W  lookup key
- wr_en  in  1  entry write strobe
- wr_addr  in  log2(DEPTH)  entry index
- wr_key  in  KEY_W  entry key
- wr_mask  in  KEY_W  care mask; 1 = compare the bit, 0 = don't care
- wr_act  in  ACT_W  entry action
- wr_valid  in  1  new valid bit for the entry; 0 deletes it
- tcam_out_vld  out  1  result strobe
- tcam_out  out  ACT_W  matched action, or DEF_ACT on miss
- tcam_hit  out  1  1 = some entry matched
- tcam_idx  out  log2(DEPTH)  winning index; 0 on miss
- hit_cnt, miss_cnt  out  32  statistics; present only with TCAM_STATS_EN

## Operation
- Entry i matches when valid[i] and ((data_in ^ key[i]) & mask[i]) == 0.
- Priority: the lowest matching index wins.
- Miss: tcam_hit=0, tcam_out=DEF_ACT, tcam_idx=0.
- Writes: on a wr_en edge, key, mask, act and valid at wr_addr update together, one write per cycle. A mask of all zeros is a wildcard entry.
- Reset: all valid bits cleared. Key, mask and action storage need not be reset. Pipeline valid bits cleared. All outputs 0. Counters 0.
- Lookup and write are independent. There is no back-pressure and every request produces exactly one result.

## Timing
- Stage 1 (edge after request): compare against the table contents as they were before that edge, and register the DEPTH-bit match vector plus valid.
- Stage 2 (next edge): priority-encode and register tcam_out_vld, tcam_hit, tcam_idx, tcam_out.
- Latency: request at edge N gives a result visible after edge N+2. Throughput is one lookup per cycle.
- Write/lookup collision:
  - A request sampled on the same edge as a write sees the old entry.
  - A request sampled one edge later sees the new entry.
- Outputs hold their last values while tcam_out_vld=0.
- Reset asserted mid-operation clears in-flight lookups immediately. No result is emitted for them.

## Configuration
- Macro TCAM_STATS_EN.
- Defined:
  - hit_cnt and miss_cnt ports exist.
  - Each increments by one on a stage-2 result with tcam_hit=1 or 0 respectively.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package tcam_pkg holds:
  - the STATS_W=32 constant
  - an entry struct typedef: key, mask, act, valid, sized from module parameters via a parametrised width function or localparams in the module.
- One sub-module, tcam_prio_enc. It is parametrised by DEPTH and converts the match vector to hit and index combinationally. tcam_lookup instantiates it in stage 2.

## Test plan
- Reset, then lookup 0x1 with the table empty: after 2 cycles tcam_out_vld=1, tcam_hit=0, tcam_out=0, tcam_idx=0.
- Write idx 3 as key 0x2, mask 0xF, act 0x5. Lookups 0x2 then 0x3 on back-to-back cycles give hit/idx 3/act 5, then miss, on consecutive cycles.
- Priority:
  - Write idx 1 as key 0x4, mask 0xC, act 0x7, and idx 2 as key 0x4, mask 0xF, act 0x9.
  - Lookup 0x4 gives idx 1, act 7.
  - Clear idx 1 with wr_valid=0; lookup 0x4 gives idx 2, act 9.
- Collision:
  - Lookup 0x6 on the same edge as a write of idx 0 (key 0x6, mask 0xF, act 0xA) gives a miss.
  - The identical lookup one cycle later gives a hit with act 0xA.
- Wildcard and reset:
  - Write idx 15 with mask 0x0, act 0xE. Any key with no earlier match returns idx 15.
  - Assert reset between request and result: no tcam_out_vld pulse, and after release every lookup misses.
- With TCAM_STATS_EN: 3 hits and 2 misses give hit_cnt=3, miss_cnt=2. A counter preloaded near max stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared constants and helpers for the ternary match table.
package tcam_pkg;

   localparam int STATS_W = 32;

   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (v == {STATS_W{1'b1}}) ? v : v + {{(STATS_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index-wins priority encoder for the ternary match vector.
module tcam_prio_enc
#(
   parameter int DEPTH = 16
) (
   input  logic [DEPTH-1:0]         match_vec,
   output logic                     hit,
   output logic [$clog2(DEPTH)-1:0] idx
);

   localparam int IDX_W = $clog2(DEPTH);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      hit = 1'b0;
      idx = {IDX_W{1'b0}};
      for (int i = DEPTH - 1; i >= 0; i--) begin
         hit = hit | match_vec[i];
         idx = match_vec[i] ? IDX_W'(i) : idx;
      end
   end

endmodule

// File: rtl/tcam_lookup.sv
// Runtime-programmable ternary match table with a two-stage lookup pipeline.
// Optional hit/miss statistics counters are built when TCAM_STATS_EN is defined.
module tcam_lookup
   import tcam_pkg::*;
#(
   parameter int                KEY_W   = 4,
   parameter int                DEPTH   = 16,
   parameter int                ACT_W   = 4,
   parameter logic [ACT_W-1:0]  DEF_ACT = {ACT_W{1'b0}}
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     data_in_vld,
   input  logic [KEY_W-1:0]         data_in,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [KEY_W-1:0]         wr_key,
   input  logic [KEY_W-1:0]         wr_mask,
   input  logic [ACT_W-1:0]         wr_act,
   input  logic                     wr_valid,
   output logic                     tcam_out_vld,
   output logic [ACT_W-1:0]         tcam_out,
   output logic                     tcam_hit,
   output logic [$clog2(DEPTH)-1:0] tcam_idx
`ifdef TCAM_STATS_EN
   ,
   output logic [STATS_W-1:0]       hit_cnt,
   output logic [STATS_W-1:0]       miss_cnt
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [KEY_W-1:0] mask;
      logic [ACT_W-1:0] act;
      logic             valid;
   } entry_t;

   entry_t             wr_entry_s;
   logic [KEY_W-1:0]   key_r  [DEPTH];
   logic [KEY_W-1:0]   mask_r [DEPTH];
   logic [ACT_W-1:0]   act_r  [DEPTH];
   logic [DEPTH-1:0]   valid_r;

   logic [DEPTH-1:0]   match_s;
   logic [DEPTH-1:0]   match_r;
   logic               s1_vld_r;
   logic               hit_s;
   logic [IDX_W-1:0]   idx_s;

   logic               out_vld_r;
   logic [ACT_W-1:0]   out_r;
   logic               hit_r;
   logic [IDX_W-1:0]   idx_r;

   assign wr_entry_s = '{key: wr_key, mask: wr_mask, act: wr_act, valid: wr_valid};

   // Entry payload storage; only the valid bits need a reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         key_r[wr_addr]  <= wr_entry_s.key;
         mask_r[wr_addr] <= wr_entry_s.mask;
         act_r[wr_addr]  <= wr_entry_s.act;
      end
   end

   // Entry valid bits, cleared on reset and updated with each write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r <= {DEPTH{1'b0}};
      end else if (wr_en) begin
         valid_r[wr_addr] <= wr_entry_s.valid;
      end
   end

   // Ternary compare of the incoming key against every entry.
   always_comb begin
      match_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         match_s[i] = valid_r[i] & (((data_in ^ key_r[i]) & mask_r[i]) == {KEY_W{1'b0}});
      end
   end

   // Stage 1: capture the match vector against the pre-edge table contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_vld_r <= 1'b0;
         match_r  <= {DEPTH{1'b0}};
      end else begin
         s1_vld_r <= data_in_vld;
         match_r  <= data_in_vld ? match_s : match_r;
      end
   end

   tcam_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
      .match_vec (match_r),
      .hit       (hit_s),
      .idx       (idx_s)
   );

   // Stage 2: register the resolved result; outputs hold between results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_vld_r <= 1'b0;
         out_r     <= {ACT_W{1'b0}};
         hit_r     <= 1'b0;
         idx_r     <= {IDX_W{1'b0}};
      end else begin
         out_vld_r <= s1_vld_r;
         if (s1_vld_r) begin
            hit_r <= hit_s;
            idx_r <= hit_s ? idx_s : {IDX_W{1'b0}};
            out_r <= hit_s ? act_r[idx_s] : DEF_ACT;
         end
      end
   end

   assign tcam_out_vld = out_vld_r;
   assign tcam_out     = out_r;
   assign tcam_hit     = hit_r;
   assign tcam_idx     = idx_r;

`ifdef TCAM_STATS_EN
   logic [STATS_W-1:0] hit_cnt_r;
   logic [STATS_W-1:0] miss_cnt_r;

   // Saturating hit/miss counters, advanced alongside each stage-2 result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_cnt_r  <= {STATS_W{1'b0}};
         miss_cnt_r <= {STATS_W{1'b0}};
      end else if (s1_vld_r) begin
         if (hit_s) begin
            hit_cnt_r <= sat_inc(hit_cnt_r);
         end else begin
            miss_cnt_r <= sat_inc(miss_cnt_r);
         end
      end
   end

   assign hit_cnt  = hit_cnt_r;
   assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_tcam_lookup.sv
// Scoreboard bench for tcam_lookup: a table model predicts each lookup at issue
// time and a negedge monitor checks every result strobe against the queue.
module tb_tcam_lookup;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       data_in_vld = 1'b0;
   logic [3:0] data_in = 4'h0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = 4'h0;
   logic [3:0] wr_key = 4'h0;
   logic [3:0] wr_mask = 4'h0;
   logic [3:0] wr_act = 4'h0;
   logic       wr_valid = 1'b0;
   logic       tcam_out_vld;
   logic [3:0] tcam_out;
   logic       tcam_hit;
   logic [3:0] tcam_idx;
`ifdef TCAM_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   tcam_lookup dut (
      .clk          (clk),
      .reset        (reset),
      .data_in_vld  (data_in_vld),
      .data_in      (data_in),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_key       (wr_key),
      .wr_mask      (wr_mask),
      .wr_act       (wr_act),
      .wr_valid     (wr_valid),
      .tcam_out_vld (tcam_out_vld),
      .tcam_out     (tcam_out),
      .tcam_hit     (tcam_hit),
      .tcam_idx     (tcam_idx)
`ifdef TCAM_STATS_EN
      ,
      .hit_cnt      (hit_cnt),
      .miss_cnt     (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       hit;
      bit [3:0] idx;
      bit [3:0] act;
   } exp_t;

   exp_t     exp_q[$];
   bit [3:0] m_key  [16];
   bit [3:0] m_mask [16];
   bit [3:0] m_act  [16];
   bit       m_valid[16];
   longint   m_hits = 0;
   longint   m_misses = 0;
   int       total = 0;
   int       bad = 0;

   function automatic exp_t model_lookup(input bit [3:0] key);
      exp_t e;
      e.hit = 1'b0; e.idx = 4'd0; e.act = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (!e.hit && m_valid[i] && (((key ^ m_key[i]) & m_mask[i]) == 4'd0)) begin
            e.hit = 1'b1; e.idx = 4'(i); e.act = m_act[i];
         end
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // One clock of stimulus: the lookup is predicted from the table before this edge's write.
   task automatic drive(input bit lk, input bit [3:0] key, input bit we, input bit [3:0] addr,
                        input bit [3:0] k, input bit [3:0] m, input bit [3:0] a, input bit v);
      data_in_vld = lk; data_in = key;
      wr_en = we; wr_addr = addr; wr_key = k; wr_mask = m; wr_act = a; wr_valid = v;
      if (lk) exp_q.push_back(model_lookup(key));
      if (we) begin
         m_key[addr] = k; m_mask[addr] = m; m_act[addr] = a; m_valid[addr] = v;
      end
      @(posedge clk); #1;
      data_in_vld = 1'b0; wr_en = 1'b0;
   endtask

   task automatic lookup(input bit [3:0] key);
      drive(1'b1, key, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
   endtask

   task automatic write(input bit [3:0] addr, input bit [3:0] k, input bit [3:0] m,
                        input bit [3:0] a, input bit v);
      drive(1'b0, 4'd0, 1'b1, addr, k, m, a, v);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every result strobe must match the oldest outstanding prediction.
   always @(negedge clk) begin
      if (tcam_out_vld) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_result: got vld=1 hit=%0d idx=%0d act=%0h, expected no result",
                     tcam_hit, tcam_idx, tcam_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (tcam_hit !== e.hit || tcam_idx !== e.idx || tcam_out !== e.act) begin
               bad++;
               $display("FAIL result: got hit=%0d idx=%0d act=%0h, expected hit=%0d idx=%0d act=%0h",
                        tcam_hit, tcam_idx, tcam_out, e.hit, e.idx, e.act);
            end
            if (e.hit) m_hits = (m_hits >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_hits + 1;
            else       m_misses = (m_misses >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_misses + 1;
`ifdef TCAM_STATS_EN
            check("hit_cnt", hit_cnt, 32'(m_hits));
            check("miss_cnt", miss_cnt, 32'(m_misses));
`endif
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_vld", 32'(tcam_out_vld), 32'd0);
      check("reset_hit", 32'(tcam_hit), 32'd0);
      check("reset_out", 32'(tcam_out), 32'd0);
      check("reset_idx", 32'(tcam_idx), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      lookup(4'h1);
      write(4'd3, 4'h2, 4'hF, 4'h5, 1'b1);
      lookup(4'h2);
      lookup(4'h3);

      write(4'd1, 4'h4, 4'hC, 4'h7, 1'b1);
      write(4'd2, 4'h4, 4'hF, 4'h9, 1'b1);
      lookup(4'h4);
      write(4'd1, 4'h4, 4'hC, 4'h7, 1'b0);
      lookup(4'h4);

      drive(1'b1, 4'h6, 1'b1, 4'd0, 4'h6, 4'hF, 4'hA, 1'b1);
      lookup(4'h6);

      write(4'd15, 4'h0, 4'h0, 4'hE, 1'b1);
      lookup(4'h9);
      lookup(4'hF);
      lookup(4'h2);
      drain();

      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 6; w++)
            write(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 3) != 0));
         for (int l = 0; l < 20; l++)
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
         drain();
      end

      write(4'd5, 4'h4, 4'hF, 4'h3, 1'b1);
      lookup(4'h4);
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_hits = 0; m_misses = 0;
      repeat (2) @(posedge clk);
      #1;
      check("midreset_vld", 32'(tcam_out_vld), 32'd0);
      check("midreset_hit", 32'(tcam_hit), 32'd0);
      check("midreset_idx", 32'(tcam_idx), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      lookup(4'h4);
      lookup(4'h6);
      lookup(4'h2);
      for (int l = 0; l < 6; l++) lookup(4'($urandom));
      drain();

`ifdef TCAM_STATS_EN
      write(4'd0, 4'h6, 4'hF, 4'hA, 1'b1);
      force dut.hit_cnt_r = 32'hFFFF_FFFE;
      #1;
      release dut.hit_cnt_r;
      m_hits = 64'hFFFF_FFFE;
      lookup(4'h6);
      lookup(4'h6);
      lookup(4'h6);
      drain();
      check("hit_cnt_sat", hit_cnt, 32'hFFFF_FFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
